// File: rtl/pn_token_tx.sv
// PN token initiator: buffers host tokens, serialises them, collects results.
// Optional pre-send structure check enabled by defining PN_STRUCT_CHECK_EN.
module pn_token_tx #(
    parameter int MAX_TOK = 12,
    parameter int TIMEOUT = 1024,
    parameter int TO_W    = 11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_valid,
    input  logic        load_operator,
    input  logic [2:0]  load_value,
    output logic        load_ready,
    input  logic        start,
    input  logic [1:0]  start_mode,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [1:0]  pn_mode,
    output logic        pn_operator,
    output logic [2:0]  pn_in,
    output logic        pn_in_valid,
    input  logic        pn_out_valid,
    input  logic [31:0] pn_out,
    output logic        res_valid,
    output logic [31:0] res_data,
    output logic [1:0]  res_idx
);
    localparam int CW = $clog2(MAX_TOK + 1);
    localparam int DW = CW + 1;

    typedef enum logic [2:0] {IDLE, CHECK, SEND, WAIT_RES, DONE} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n, idx, idx_n, cnt_ld;
    logic [1:0]      mode_q, mode_n;
    logic [2:0]      rcv, rcv_n, exp_res;
    logic [TO_W-1:0] tmr, tmr_n;
    logic [1:0]      ec_n, pn_mode_n;
    logic            pn_op_n, pn_iv_n, res_valid_n;
    logic [2:0]      pn_in_n;
    logic [31:0]     res_data_n;
    logic [1:0]      res_idx_n;
    logic            ld, len_ok;

    logic [MAX_TOK-1:0] tok_op;
    logic [2:0]         tok_val [MAX_TOK];

    assign load_ready = (state == IDLE) && (cnt < CW'(MAX_TOK));
    assign ld         = load_valid && load_ready;
    assign cnt_ld     = cnt + CW'(ld);
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign err        = done && (err_code != 2'd0);
    assign exp_res    = mode_q[1] ? 3'd1 : 3'(cnt / CW'(3));

    always_comb begin
        if (start_mode[1]) begin
            len_ok = cnt_ld[0];
        end else begin
            len_ok = (cnt_ld >= CW'(3)) && (cnt_ld % CW'(3) == '0)
                  && (cnt_ld <= CW'(12));
        end
    end

`ifdef PN_STRUCT_CHECK_EN
    logic struct_ok;

    // Modes 2/3 scan operand/operator depth; modes 0/1 check slot positions.
    always_comb begin
        logic [CW-1:0] p;
        logic [DW-1:0] d;
        logic          bad;
        p   = '0;
        d   = '0;
        bad = 1'b0;
        for (int i = 0; i < MAX_TOK; i++) begin
            if (CW'(i) < cnt) begin
                if (mode_q[1]) begin
                    p = mode_q[0] ? CW'(i) : cnt - CW'(i + 1);
                    if (!tok_op[p]) begin
                        d = d + 1'b1;
                    end else if (d < DW'(2)) begin
                        bad = 1'b1;
                    end else begin
                        d = d - 1'b1;
                    end
                end else begin
                    p = CW'(i % 3);
                    if (tok_op[CW'(i)] != (p == (mode_q[0] ? CW'(2) : CW'(0))))
                        bad = 1'b1;
                end
            end
        end
        if (mode_q[1] && d != DW'(1)) bad = 1'b1;
        struct_ok = !bad;
    end
`endif

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        idx_n       = idx;
        mode_n      = mode_q;
        rcv_n       = rcv;
        tmr_n       = tmr;
        ec_n        = err_code;
        pn_mode_n   = '0;
        pn_op_n     = 1'b0;
        pn_in_n     = '0;
        pn_iv_n     = 1'b0;
        res_valid_n = 1'b0;
        res_data_n  = res_data;
        res_idx_n   = res_idx;
        unique case (state)
            IDLE: begin
                cnt_n = cnt_ld;
                if (start) begin
                    mode_n = start_mode;
                    rcv_n  = '0;
                    tmr_n  = '0;
                    ec_n   = 2'd0;
                    idx_n  = CW'(1);
                    if (!len_ok) begin
                        state_n = DONE;
                        ec_n    = 2'd1;
                        cnt_n   = '0;
                    end else begin
`ifdef PN_STRUCT_CHECK_EN
                        state_n = CHECK;
`else
                        // An empty buffer means token 0 arrives this cycle.
                        state_n   = SEND;
                        pn_iv_n   = 1'b1;
                        pn_mode_n = start_mode;
                        pn_op_n   = (cnt == '0) ? load_operator : tok_op[0];
                        pn_in_n   = (cnt == '0) ? load_value : tok_val[0];
`endif
                    end
                end
            end
`ifdef PN_STRUCT_CHECK_EN
            CHECK: begin
                if (struct_ok) begin
                    state_n   = SEND;
                    pn_iv_n   = 1'b1;
                    pn_mode_n = mode_q;
                    pn_op_n   = tok_op[0];
                    pn_in_n   = tok_val[0];
                end else begin
                    state_n = DONE;
                    ec_n    = 2'd2;
                end
            end
`endif
            SEND: begin
                if (idx < cnt) begin
                    pn_iv_n = 1'b1;
                    pn_op_n = tok_op[idx];
                    pn_in_n = tok_val[idx];
                    idx_n   = idx + CW'(1);
                end else begin
                    state_n = WAIT_RES;
                    tmr_n   = '0;
                end
            end
            WAIT_RES: begin
                tmr_n = tmr + 1'b1;
                if (pn_out_valid) begin
                    res_valid_n = 1'b1;
                    res_data_n  = pn_out;
                    res_idx_n   = rcv[1:0];
                    rcv_n       = rcv + 3'd1;
                end
                if (pn_out_valid && rcv_n == exp_res) begin
                    state_n = DONE;
                end else if (tmr == TO_W'(TIMEOUT - 1)) begin
                    state_n = DONE;
                    ec_n    = 2'd3;
                end
            end
            DONE: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            mode_q      <= '0;
            rcv         <= '0;
            tmr         <= '0;
            err_code    <= '0;
            pn_mode     <= '0;
            pn_operator <= 1'b0;
            pn_in       <= '0;
            pn_in_valid <= 1'b0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_idx     <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            idx         <= idx_n;
            mode_q      <= mode_n;
            rcv         <= rcv_n;
            tmr         <= tmr_n;
            err_code    <= ec_n;
            pn_mode     <= pn_mode_n;
            pn_operator <= pn_op_n;
            pn_in       <= pn_in_n;
            pn_in_valid <= pn_iv_n;
            res_valid   <= res_valid_n;
            res_data    <= res_data_n;
            res_idx     <= res_idx_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tok_op <= '0;
            for (int i = 0; i < MAX_TOK; i++) tok_val[i] <= '0;
        end else if (ld) begin
            tok_op[cnt]  <= load_operator;
            tok_val[cnt] <= load_value;
        end
    end
endmodule

// File: tb/tb_pn_token_tx.sv
// Directed table-driven bench for pn_token_tx with a scripted PN responder.
// Expected values are hand-computed; PN_STRUCT_CHECK_EN selects the variant.
module tb_pn_token_tx;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_operator = 1'b0;
    logic [2:0]  load_value = '0;
    logic        load_ready;
    logic        start = 1'b0;
    logic [1:0]  start_mode = '0;
    logic        busy, done, err;
    logic [1:0]  err_code, pn_mode;
    logic        pn_operator, pn_in_valid;
    logic [2:0]  pn_in;
    logic        pn_out_valid = 1'b0;
    logic [31:0] pn_out = '0;
    logic        res_valid;
    logic [31:0] res_data;
    logic [1:0]  res_idx;

`ifdef PN_STRUCT_CHECK_EN
    localparam int FIRST = 2;
`else
    localparam int FIRST = 1;
`endif

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [1:0]  mode;
        int          ntok;
        logic        op [12];
        logic [2:0]  val [12];
        bit          overlap;
        int          nsent;
        int          nres;
        logic [31:0] res [4];
        logic [1:0]  ec;
        int          done_t;
    } vec_t;

    vec_t vq[$];
    vec_t v, v12;

    pn_token_tx #(.MAX_TOK(12), .TIMEOUT(16), .TO_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .load_valid(load_valid), .load_operator(load_operator),
        .load_value(load_value), .load_ready(load_ready),
        .start(start), .start_mode(start_mode),
        .busy(busy), .done(done), .err(err), .err_code(err_code),
        .pn_mode(pn_mode), .pn_operator(pn_operator), .pn_in(pn_in),
        .pn_in_valid(pn_in_valid), .pn_out_valid(pn_out_valid),
        .pn_out(pn_out), .res_valid(res_valid), .res_data(res_data),
        .res_idx(res_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t blank(input logic [1:0] m);
        vec_t r;
        r.mode = m; r.ntok = 0; r.overlap = 1'b0; r.nsent = 0;
        r.nres = 0; r.ec = 2'd0; r.done_t = 0;
        for (int i = 0; i < 12; i++) begin
            r.op[i] = 1'b0;
            r.val[i] = '0;
        end
        for (int i = 0; i < 4; i++) r.res[i] = '0;
        return r;
    endfunction

    function automatic vec_t tk(input vec_t r, input bit o, input int x);
        r.op[r.ntok] = o;
        r.val[r.ntok] = 3'(x);
        r.ntok++;
        return r;
    endfunction

    task automatic run_frame(input vec_t f, input bit skip_load);
        int  sent, ngot, ri, last_t;
        bit  got;
        sent = 0; ngot = 0; ri = 0; last_t = -1; got = 0;
        if (!skip_load) begin
            for (int i = 0; i < f.ntok - (f.overlap ? 1 : 0); i++) begin
                @(negedge clk);
                load_valid = 1'b1;
                load_operator = f.op[i];
                load_value = f.val[i];
            end
        end
        @(negedge clk);
        load_valid = f.overlap;
        if (f.overlap) begin
            load_operator = f.op[f.ntok-1];
            load_value = f.val[f.ntok-1];
        end
        start = 1'b1;
        start_mode = f.mode;
        for (int t = 1; t <= 300 && !got; t++) begin
            @(negedge clk);
            start = 1'b0;
            load_valid = 1'b0;
            pn_out_valid = 1'b0;
            chk("busy", int'(busy), 1);
            if (pn_in_valid) begin
                if (sent < f.nsent) begin
                    chk("tok_time", t, FIRST + sent);
                    chk("tok_op", int'(pn_operator), int'(f.op[sent]));
                    chk("tok_val", int'(pn_in), int'(f.val[sent]));
                    chk("tok_mode", int'(pn_mode), sent == 0 ? int'(f.mode) : 0);
                end else begin
                    chk("tok_extra", sent + 1, f.nsent);
                end
                sent++;
            end else begin
                chk("bus_idle", int'({pn_mode, pn_operator, pn_in}), 0);
            end
            if (res_valid) begin
                if (ngot < f.nres) begin
                    chk("res_data", int'(res_data), int'(f.res[ngot]));
                    chk("res_idx", int'(res_idx), ngot);
                end else begin
                    chk("res_extra", ngot + 1, f.nres);
                end
                ngot++;
                last_t = t;
            end
            if (done) begin
                got = 1;
                chk("err_code", int'(err_code), int'(f.ec));
                chk("err", int'(err), int'(f.ec != 2'd0));
                chk("done_time", t, f.done_t > 0 ? f.done_t : last_t);
                chk("n_sent", sent, f.nsent);
                chk("n_res", ngot, f.nres);
            end else if (sent == f.nsent && !pn_in_valid && ri < f.nres) begin
                pn_out_valid = 1'b1;
                pn_out = f.res[ri];
                ri++;
            end
        end
        if (!got) chk("done_seen", 0, 1);
        @(negedge clk);
        chk("post_busy", int'(busy), 0);
        chk("post_done", int'(done), 0);
        chk("post_ready", int'(load_ready), 1);
        chk("ec_hold", int'(err_code), int'(f.ec));
    endtask

    initial begin
        v = blank(3);
        v = tk(v, 0, 3); v = tk(v, 0, 4); v = tk(v, 1, 0);
        v.nsent = 3; v.nres = 1; v.res[0] = 7;
        vq.push_back(v);

        v = blank(0);
        v = tk(v, 1, 2); v = tk(v, 0, 3); v = tk(v, 0, 2);
        v = tk(v, 1, 0); v = tk(v, 0, 1); v = tk(v, 0, 1);
        v.nsent = 6; v.nres = 2; v.res[0] = 6; v.res[1] = 2;
        vq.push_back(v);

        v = blank(1);
        v = tk(v, 0, 1); v = tk(v, 0, 2); v = tk(v, 1, 0); v = tk(v, 0, 3);
        v.ec = 2'd1; v.done_t = 1;
        vq.push_back(v);

        v = blank(3);
        v = tk(v, 0, 3); v = tk(v, 0, 4); v = tk(v, 1, 0);
        v.nsent = 3; v.ec = 2'd3; v.done_t = FIRST + 3 + 16;
        vq.push_back(v);

        v = blank(3);
        v = tk(v, 0, 3); v = tk(v, 1, 0); v = tk(v, 0, 4);
`ifdef PN_STRUCT_CHECK_EN
        v.ec = 2'd2; v.done_t = 2;
`else
        v.nsent = 3; v.nres = 1; v.res[0] = 7;
`endif
        vq.push_back(v);

        v = blank(2);
        v = tk(v, 1, 0); v = tk(v, 0, 3); v = tk(v, 0, 4);
        v.nsent = 3; v.nres = 1; v.res[0] = 7;
        vq.push_back(v);

        v = blank(1);
        v = tk(v, 0, 1); v = tk(v, 0, 6); v = tk(v, 1, 1);
        v.nsent = 3; v.nres = 1; v.res[0] = -5;
        vq.push_back(v);

        v = blank(0);
        v.ec = 2'd1; v.done_t = 1;
        vq.push_back(v);

        v = blank(2);
        v = tk(v, 0, 1); v = tk(v, 0, 2);
        v.ec = 2'd1; v.done_t = 1;
        vq.push_back(v);

        v = blank(2);
        v = tk(v, 0, 5);
        v.overlap = 1'b1; v.nsent = 1; v.nres = 1; v.res[0] = 5;
        vq.push_back(v);

        v = blank(3);
        v = tk(v, 0, 3); v = tk(v, 0, 4); v = tk(v, 1, 0);
        v.overlap = 1'b1; v.nsent = 3; v.nres = 1; v.res[0] = 7;
        vq.push_back(v);

        v12 = blank(0);
        v12 = tk(v12, 1, 0); v12 = tk(v12, 0, 1); v12 = tk(v12, 0, 2);
        v12 = tk(v12, 1, 1); v12 = tk(v12, 0, 5); v12 = tk(v12, 0, 2);
        v12 = tk(v12, 1, 2); v12 = tk(v12, 0, 2); v12 = tk(v12, 0, 3);
        v12 = tk(v12, 1, 3); v12 = tk(v12, 0, 1); v12 = tk(v12, 0, 2);
        v12.nsent = 12; v12.nres = 4;
        v12.res[0] = 3; v12.res[1] = 3; v12.res[2] = 6; v12.res[3] = 3;

        repeat (3) @(negedge clk);
        chk("rst_ctrl", int'({busy, done, err, err_code}), 0);
        chk("rst_bus", int'({pn_mode, pn_operator, pn_in, pn_in_valid}), 0);
        chk("rst_res", int'({res_valid, res_idx}), 0);
        chk("rst_data", int'(res_data), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_idle", int'(load_ready), 1);

        pn_out_valid = 1'b1;
        pn_out = 32'd99;
        @(negedge clk);
        pn_out_valid = 1'b0;
        @(negedge clk);
        chk("idle_res_ignored", int'(res_valid), 0);

        for (int i = 0; i < vq.size(); i++) run_frame(vq[i], 1'b0);

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            chk("ready_fill", int'(load_ready), i < 12 ? 1 : 0);
            load_valid = 1'b1;
            load_operator = (i < 12) ? v12.op[i] : 1'b0;
            load_value = (i < 12) ? v12.val[i] : 3'd7;
        end
        run_frame(v12, 1'b1);

        v = blank(3);
        v = tk(v, 0, 3); v = tk(v, 0, 4); v = tk(v, 1, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            load_valid = 1'b1;
            load_operator = v.op[i];
            load_value = v.val[i];
        end
        @(negedge clk);
        load_valid = 1'b0;
        start = 1'b1;
        start_mode = 2'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_bus", int'({pn_in_valid, done, res_valid}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        v = blank(3);
        v.ec = 2'd1; v.done_t = 1;
        run_frame(v, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/pn_token_tx.md
Name: pn_token_tx

Overview:
- Initiator side of the Polish-Notation token interface: buffers a host-loaded token frame and serialises it onto the PN bus (mode/operator/in/in_valid).
- Collects the calculator's out_valid/out responses and hands them back to the host with an index, plus completion and error status.
- Sits between the host/test sequencer and the PN calculator core.

Parameters:
- MAX_TOK, 12, token buffer depth; maximum tokens per frame.
- TIMEOUT, 1024, cycles allowed in WAIT_RES before timeout error.
- TO_W, 11, width of timeout counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- load_valid  in  1  host token write strobe
- load_operator  in  1  token is operator (1) / operand (0)
- load_value  in  3  operand value, or operator code (0 add, 1 sub, 2 mul, 3 abs-sum)
- load_ready  out  1  buffer accepts a token this cycle
- start  in  1  launch frame (1-cycle pulse)
- start_mode  in  2  PN mode for the frame (0..3)
- busy  out  1  frame in progress
- done  out  1  1-cycle frame completion pulse
- err  out  1  valid with done; frame failed
- err_code  out  2  0 none, 1 length, 2 structure, 3 timeout; held until next start
- pn_mode  out  2  mode to calculator
- pn_operator  out  1  token flag to calculator
- pn_in  out  3  token value to calculator
- pn_in_valid  out  1  token strobe to calculator
- pn_out_valid  in  1  calculator result strobe
- pn_out  in  32  calculator result, signed
- res_valid  out  1  forwarded result strobe
- res_data  out  32  forwarded result, signed
- res_idx  out  2  result index within frame (0..3)

Behaviour:
- Reset: all outputs 0; buffer count 0; state IDLE. Reset mid-frame aborts immediately and discards buffer; no done.
- All PN-bus and result outputs are registered.
- load_ready = (state==IDLE) && (cnt<MAX_TOK). Accepted tokens are stored in load order. load_valid while !load_ready is dropped silently.
- States and transitions:
  - IDLE: start while cnt_next>0 and the length check passes -> SEND. cnt_next includes a token loaded in the same cycle.
  - SEND: tokens are driven for cnt consecutive cycles with pn_in_valid=1. pn_mode=start_mode only on the first token cycle, otherwise 0. After the last token -> WAIT_RES.
  - WAIT_RES: pn_in_valid=0, pn_operator/pn_in=0. Each pn_out_valid registers res_data=pn_out and res_valid=1 one cycle later; res_idx starts at 0 and increments. When the received count equals expected -> DONE. Timeout counter reaching TIMEOUT -> DONE with err_code=3.
  - DONE: done=1 for one cycle; err=(err_code!=0); cnt cleared -> IDLE.
- Expected results: modes 0/1 = cnt/3; modes 2/3 = 1.
- Length check:
  - Modes 0/1 fail when cnt<3, cnt%3!=0, or cnt>12.
  - Modes 2/3 fail when cnt is even.
  - On failure (or start with cnt_next=0): no PN traffic, done+err with err_code=1 on cycle T+1, buffer cleared.
- Latency: start at cycle T -> first pn_in_valid at T+1. Last token at T+cnt.
- busy=1 from T+1 through the DONE cycle. start while busy is ignored.
- pn_out_valid outside WAIT_RES is ignored; no res_valid.
- Simultaneous pn_out_valid and timeout expiry: the result is forwarded and completion takes precedence; err_code=0 if count is then met.

Optional Feature:
- Macro PN_STRUCT_CHECK_EN.
- Defined: before SEND, a structural check runs, adding 1 cycle of latency so first pn_in_valid is at T+2.
  - Mode 0: every group has operator at position 0 and operands at 1 and 2.
  - Mode 1: operator at position 2 of every group.
  - Mode 3: left-to-right stack-depth scan never underflows and ends at depth 1.
  - Mode 2: the same scan runs right-to-left.
  - Failure: no traffic, done+err with err_code=2 at T+2.
- Undefined: no structural check; malformed frames are transmitted as-is.

Test Plan:
- Mode 3, load (0,3),(0,4),(1,0), start -> pn_in_valid T+1..T+3 with pn_mode=3 only at T+1; responder returns 7 -> res_data=7, res_idx=0, done=1, err=0.
- Mode 0, load (1,2),(0,3),(0,2),(1,0),(0,1),(0,1) -> 6 tokens sent; responder returns 6 then 2 -> res_idx 0,1 with data 6,2; done after second.
- Mode 1 with 4 tokens -> pn_in_valid never asserted; done=1, err=1, err_code=1 at T+1.
- TIMEOUT=16, no responder -> done=1, err_code=3 exactly 16 cycles after entering WAIT_RES.
- 13 load pulses -> load_ready low after the 12th; the 13th is dropped; 12 tokens transmitted.
- Mode 3 tokens 3,+,4 -> with PN_STRUCT_CHECK_EN: err_code=2 and no traffic; without it: 3 tokens transmitted.
